// File: rtl/ball_motion_if.sv
// Ball motion stage bus: control strobes, speed and paddle inputs, position/status outputs.
interface ball_motion_if;
    logic       move_tick;
    logic       launch;
    logic       bounce_x;
    logic       bounce_y;
    logic [3:0] b_sx;
    logic [3:0] b_sy;
    logic [9:0] p_x;
    logic [5:0] p_radius;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic       bd;
    logic       dir_x;
    logic       dir_y;
    logic       paddle_hit;
    logic       ball_lost;

    modport slave (
        input  move_tick, launch, bounce_x, bounce_y, b_sx, b_sy, p_x, p_radius,
        output b_x, b_y, bd, dir_x, dir_y, paddle_hit, ball_lost
    );

    modport master (
        output move_tick, launch, bounce_x, bounce_y, b_sx, b_sy, p_x, p_radius,
        input  b_x, b_y, bd, dir_x, dir_y, paddle_hit, ball_lost
    );
endinterface

// File: rtl/ball_motion.sv
// Ball position integrator (10.2 fixed point) with wall/ceiling/paddle/brick reflection
// and the serve / move / lost life cycle.
module ball_motion #(
    parameter int unsigned X_MIN     = 8,
    parameter int unsigned X_MAX     = 631,
    parameter int unsigned Y_MIN     = 8,
    parameter int unsigned PADDLE_Y  = 440,
    parameter int unsigned Y_MAX     = 479,
    parameter int unsigned BALL_R    = 4,
    parameter int unsigned LOST_HOLD = 60
) (
    input  logic          clock,
    input  logic          reset,
    ball_motion_if.slave  bus
);
    localparam int unsigned PW = 12;
    localparam int unsigned CW = (LOST_HOLD > 1) ? $clog2(LOST_HOLD) : 1;

    localparam logic [PW-1:0]    SERVE_Y  = PW'((PADDLE_Y - BALL_R) << 2);
    localparam logic [PW-1:0]    CENTRE_X = PW'(320 << 2);
    localparam logic [PW-1:0]    XMIN_Q   = PW'(X_MIN << 2);
    localparam logic [PW-1:0]    XMAX_Q   = PW'(X_MAX << 2);
    localparam logic [PW-1:0]    YMIN_Q   = PW'(Y_MIN << 2);
    localparam logic signed [12:0] XMIN_S  = 13'(X_MIN << 2);
    localparam logic signed [12:0] XMAX_S  = 13'(X_MAX << 2);
    localparam logic signed [12:0] YMIN_S  = 13'(Y_MIN << 2);
    localparam logic signed [12:0] YMAX_S  = 13'(Y_MAX << 2);
    localparam logic signed [12:0] SERVE_S = 13'((PADDLE_Y - BALL_R) << 2);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_LOST} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   px_q, px_d, py_q, py_d;
    logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic            bd_q, bd_d, hit_q, hit_d, lost_q, lost_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic signed [12:0] nx, ny;
    logic [PW-1:0]      px_new;
    logic [9:0]         bx_next;
    logic [10:0]        lo_sum, hi_sum;
    logic               overlap;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            px_q    <= CENTRE_X;
            py_q    <= SERVE_Y;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b0;
            bd_q    <= 1'b0;
            hit_q   <= 1'b0;
            lost_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            bd_q    <= bd_d;
            hit_q   <= hit_d;
            lost_q  <= lost_d;
            cnt_q   <= cnt_d;
        end
    end

    // Candidate position, horizontal response and paddle overlap on the updated x.
    always_comb begin
        nx = dir_x_q ? (13'(px_q) + 13'(bus.b_sx)) : (13'(px_q) - 13'(bus.b_sx));
        ny = dir_y_q ? (13'(py_q) + 13'(bus.b_sy)) : (13'(py_q) - 13'(bus.b_sy));
        if (nx < XMIN_S) begin
            px_new = XMIN_Q;
        end else if (nx > XMAX_S) begin
            px_new = XMAX_Q;
        end else begin
            px_new = nx[PW-1:0];
        end
        bx_next = px_new[PW-1:2];
        lo_sum  = 11'(bx_next) + 11'(bus.p_radius);
        hi_sum  = 11'(bus.p_x) + 11'(bus.p_radius);
        overlap = (lo_sum >= 11'(bus.p_x)) && (11'(bx_next) <= hi_sum);
    end

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        hit_d   = 1'b0;
        lost_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                px_d = {bus.p_x, 2'b00};
                py_d = SERVE_Y;
                if (bus.launch) begin
                    state_d = S_MOVE;
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                end
            end
            S_MOVE: begin
                if (bus.move_tick) begin
                    if (nx < XMIN_S) begin
                        dir_x_d = 1'b1;
                    end else if (nx > XMAX_S) begin
                        dir_x_d = 1'b0;
                    end else if (bus.bounce_x) begin
                        dir_x_d = ~dir_x_q;
                    end
                    px_d = px_new;

                    if (ny < YMIN_S) begin
                        py_d    = YMIN_Q;
                        dir_y_d = 1'b1;
                    end else if (dir_y_q && (ny >= SERVE_S) && (py_q < SERVE_Y) && overlap) begin
                        py_d    = SERVE_Y;
                        dir_y_d = 1'b0;
                        hit_d   = 1'b1;
                    end else if (ny > YMAX_S) begin
                        // Ball is frozen where it left the playfield.
                        state_d = S_LOST;
                        lost_d  = 1'b1;
                        cnt_d   = '0;
                        px_d    = px_q;
                    end else begin
                        py_d = ny[PW-1:0];
                        if (bus.bounce_y) begin
                            dir_y_d = ~dir_y_q;
                        end
                    end
                end else begin
                    if (bus.bounce_x) dir_x_d = ~dir_x_q;
                    if (bus.bounce_y) dir_y_d = ~dir_y_q;
                end
            end
            S_LOST: begin
                if (bus.move_tick) begin
                    if (cnt_q == CW'(LOST_HOLD - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        bd_d = (state_d == S_MOVE);
    end

    assign bus.b_x        = px_q[PW-1:2];
    assign bus.b_y        = py_q[PW-1:2];
    assign bus.bd         = bd_q;
    assign bus.dir_x      = dir_x_q;
    assign bus.dir_y      = dir_y_q;
    assign bus.paddle_hit = hit_q;
    assign bus.ball_lost  = lost_q;
endmodule
